// File: rtl/ldl_wround.sv
// Weighted round-robin arbiter: each requestor holds the grant for weight+1
// accepted grants, then the search resumes just past it.

module ldl_wround_lane #(
  parameter int BIN_WIDTH = 3,
  parameter int IDX       = 0
) (
  input  logic                 req_bit,
  input  logic [BIN_WIDTH-1:0] start,
  output logic                 upper
);
  // Lane is a candidate in the first (non-wrapped) half of the circular search.
  assign upper = req_bit && (BIN_WIDTH'(IDX) >= start);
endmodule

module ldl_wround #(
  parameter int REQ_WIDTH = 8,
  parameter int BIN_WIDTH = $clog2(REQ_WIDTH),
  parameter int WGT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQ_WIDTH-1:0]           req,
  input  logic [REQ_WIDTH*WGT_WIDTH-1:0] weight,
  input  logic                           ready,
  output logic                           valid,
  output logic [REQ_WIDTH-1:0]           hot,
  output logic [BIN_WIDTH-1:0]           bin,
  output logic                           last
);

  logic [WGT_WIDTH-1:0] credit;
  logic [BIN_WIDTH-1:0] ptr;
  logic [BIN_WIDTH-1:0] bin_inc;
  logic [BIN_WIDTH-1:0] start;
  logic [BIN_WIDTH-1:0] sel_hi;
  logic [BIN_WIDTH-1:0] sel_lo;
  logic [BIN_WIDTH-1:0] sel;
  logic [WGT_WIDTH-1:0] wsel;
  logic [REQ_WIDTH-1:0] upper;
  logic                 acc;
  logic                 dec;
  logic                 cont;

  assign acc     = valid & ready;
  assign dec     = ~valid | ready;
  assign bin_inc = (bin == BIN_WIDTH'(REQ_WIDTH-1)) ? '0 : bin + 1'b1;
  assign start   = acc ? bin_inc : ptr;
  assign cont    = acc && (credit != '0) && req[bin];
  assign last    = valid && (credit == '0);

  for (genvar i = 0; i < REQ_WIDTH; i++) begin : g_lane
    ldl_wround_lane #(.BIN_WIDTH(BIN_WIDTH), .IDX(i)) u_lane (
      .req_bit (req[i]),
      .start   (start),
      .upper   (upper[i])
    );
  end

  // Lowest candidate at/after start wins; otherwise wrap to the lowest request.
  always_comb begin
    sel_hi = '0;
    sel_lo = '0;
    for (int i = REQ_WIDTH-1; i >= 0; i--) begin
      if (upper[i]) sel_hi = BIN_WIDTH'(i);
      if (req[i])   sel_lo = BIN_WIDTH'(i);
    end
    sel  = (|upper) ? sel_hi : sel_lo;
    wsel = '0;
    for (int i = 0; i < REQ_WIDTH; i++)
      if (sel == BIN_WIDTH'(i)) wsel = weight[i*WGT_WIDTH +: WGT_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      hot    <= '0;
      bin    <= '0;
      credit <= '0;
      ptr    <= '0;
    end else if (dec) begin
      if (acc) ptr <= bin_inc;
      if (cont) begin
        credit <= credit - 1'b1;
      end else if (|req) begin
        valid  <= 1'b1;
        bin    <= sel;
        hot    <= REQ_WIDTH'(1) << sel;
        credit <= wsel;
      end else begin
        valid  <= 1'b0;
        hot    <= '0;
        credit <= '0;
      end
    end
  end

endmodule
